// File: rtl/present_p_layer_if.sv
// present_p_layer_if: state, valid and result signals of the PRESENT P-layer (inverse port under PLAYER_INVERSE_EN)
interface present_p_layer_if #(parameter int WIDTH = 64);
  logic [WIDTH-1:0] original;
  logic [WIDTH-1:0] permuted;
  logic [WIDTH-1:0] permuted_q;
  logic             in_valid;
  logic             out_valid;
`ifdef PLAYER_INVERSE_EN
  logic             inverse;
  modport master (output original, in_valid, inverse, input permuted, permuted_q, out_valid);
  modport slave  (input original, in_valid, inverse, output permuted, permuted_q, out_valid);
`else
  modport master (output original, in_valid, input permuted, permuted_q, out_valid);
  modport slave  (input original, in_valid, output permuted, permuted_q, out_valid);
`endif
endinterface

// File: rtl/present_p_layer.sv
// present_p_layer: PRESENT bit permutation with combinational and registered outputs; PLAYER_INVERSE_EN adds the decryption mapping
module present_p_layer #(
  parameter int WIDTH = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  present_p_layer_if.slave        bus
);
  localparam int Q = WIDTH / 4;
  localparam int M = WIDTH - 1;
  logic [WIDTH-1:0] fwd;
  logic [WIDTH-1:0] perm;
  logic [WIDTH-1:0] data_d;
  logic [WIDTH-1:0] data_q;
  logic             valid_d;
  logic             valid_q;
  // Forward wiring: bit i lands at Q*i mod M, top bit stays put
  for (genvar i = 0; i < WIDTH; i++) begin : g_fwd
    assign fwd[(i == M) ? M : (Q * i) % M] = bus.original[i];
  end
`ifdef PLAYER_INVERSE_EN
  logic [WIDTH-1:0] inv;
  // Inverse wiring: bit i lands at 4*i mod M, top bit stays put
  for (genvar i = 0; i < WIDTH; i++) begin : g_inv
    assign inv[(i == M) ? M : (4 * i) % M] = bus.original[i];
  end
  assign perm = bus.inverse ? inv : fwd;
`else
  assign perm = fwd;
`endif
  assign bus.permuted   = perm;
  assign bus.permuted_q = data_q;
  assign bus.out_valid  = valid_q;
  // Capture on in_valid, otherwise hold the result and drop valid
  always_comb begin
    data_d  = bus.in_valid ? perm : data_q;
    valid_d = bus.in_valid;
  end
  // Output register with asynchronous active-low clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end
endmodule

// File: tb/tb_present_p_layer.sv
// tb_present_p_layer: scoreboard bench for present_p_layer with directed vectors
module tb_present_p_layer;
  logic clk;
  logic reset;
  int checks;
  int errors;
  logic [63:0] exp_q[$];
  present_p_layer_if #(.WIDTH(64)) bus ();
  present_p_layer #(.WIDTH(64)) dut (.clk(clk), .reset(reset), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Lane view of the permutation: nibble j bit k goes to lane k position j
  function automatic logic [63:0] model_fwd(input logic [63:0] v);
    logic [63:0] r;
    for (int j = 0; j < 16; j++)
      for (int k = 0; k < 4; k++)
        r[k*16+j] = v[4*j+k];
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [63:0] v, input logic [63:0] exp);
    bus.original = v;
    bus.in_valid = 1'b1;
    #1 chk("permuted", bus.permuted, exp);
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
  endtask

  // Monitor: every valid registered result must match the oldest expectation
  always @(negedge clk) begin
    if (bus.out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got %h expected no output", bus.permuted_q);
      end else begin
        chk("permuted_q", bus.permuted_q, exp_q.pop_front());
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] r;
    logic [63:0] p;
    checks = 0;
    errors = 0;
    reset = 1'b0;
    bus.original = '0;
    bus.in_valid = 1'b0;
`ifdef PLAYER_INVERSE_EN
    bus.inverse = 1'b0;
`endif
    #2;
    chk("reset_q", bus.permuted_q, 64'h0);
    chk("reset_valid", {63'd0, bus.out_valid}, 64'h0);
    bus.original = 64'h2;
    #1 chk("comb_in_reset", bus.permuted, 64'h10000);
    @(posedge clk);
    #1 reset = 1'b1;
    issue(64'h000000000000000F, 64'h0001000100010001);
    bus.in_valid = 1'b0;
    bus.original = 64'hFFFFFFFFFFFFFFFF;
    @(posedge clk);
    #1;
    chk("idle_valid", {63'd0, bus.out_valid}, 64'h0);
    chk("hold_q", bus.permuted_q, 64'h0001000100010001);
    issue(64'h0000000000000001, 64'h0000000000000001);
    issue(64'h0000000000000002, 64'h0000000000010000);
    issue(64'h0000000000000010, 64'h0000000000000002);
    issue(64'h8000000000000000, 64'h8000000000000000);
    issue(64'h000000000000FFFF, 64'h000F000F000F000F);
    issue(64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF);
    issue(64'h0000000000000000, 64'h0000000000000000);
    for (int i = 0; i < 64; i++)
      issue(64'd1 << i, 64'd1 << ((i == 63) ? 63 : (16 * i) % 63));
    for (int i = 0; i < 20; i++) begin
      r = {$urandom, $urandom};
      issue(r, model_fwd(r));
    end
    issue(64'h0123456789ABCDEF, 64'h00FF0F0F33335555);
    @(negedge clk);
    #1 reset = 1'b0;
    #1;
    chk("midreset_q", bus.permuted_q, 64'h0);
    chk("midreset_valid", {63'd0, bus.out_valid}, 64'h0);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
`ifdef PLAYER_INVERSE_EN
    bus.inverse = 1'b1;
    issue(64'h0000000000010000, 64'h0000000000000002);
    bus.in_valid = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      r = {$urandom, $urandom};
      bus.inverse = 1'b0;
      bus.original = r;
      #1 p = bus.permuted;
      bus.inverse = 1'b1;
      bus.original = p;
      #1 chk("roundtrip", bus.permuted, r);
    end
    bus.inverse = 1'b0;
`endif
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule

// File: doc/present_p_layer.md
Name: present_p_layer

Overview:
- Bit-permutation layer (P-layer) of a PRESENT-style SPN block cipher. It sits between the S-box layer and the next round-key addition.
- Provides a purely combinational permuted output plus a registered copy with a valid flag for pipelined round datapaths.
- Stateless apart from the optional output register stage.

Parameters:
- WIDTH, 64, state width in bits; must be a multiple of 4 and ≥ 8.

Ports:
- clk  input  1  rising-edge clock; used only by the output register stage.
- reset  input  1  asynchronous, active-low reset.
- original  input  WIDTH  state before permutation.
- in_valid  input  1  qualifies `original` for capture into the output register.
- permuted  output  WIDTH  combinational permutation of `original`.
- permuted_q  output  WIDTH  registered permutation.
- out_valid  output  1  `permuted_q` holds a valid result.

Behaviour:
- Let Q = WIDTH/4 and M = WIDTH-1.
- Forward mapping:
  - For source bit i with 0 ≤ i < M: permuted[(Q*i) mod M] = original[i].
  - Top bit is fixed: permuted[M] = original[M].
  - For WIDTH = 64 this is the standard PRESENT P-layer: P(i) = 16i mod 63, P(63) = 63.
- Equivalent view of the forward mapping: bit 4j+k of the input (nibble j, bit k) goes to bit k*Q+j. Bit k of every nibble is gathered into lane k.
- The mapping is a bijection, with no inversion and no constants. All-zeros and all-ones are fixed points.
- `permuted` is pure combinational logic from `original`, with zero latency and no dependence on clk or reset. It must settle within half a clock period.
- Register stage, on clk rising edge:
  - When in_valid = 1: permuted_q <= permuted and out_valid <= 1.
  - When in_valid = 0: permuted_q holds its value and out_valid <= 0.
  - Latency is exactly 1 cycle, with throughput of one result per cycle.
- Reset: when reset = 0, asynchronously clear permuted_q to all-zeros and out_valid to 0. `permuted` is unaffected.
- Reset deasserts synchronously to clk. The first capture is possible on the first rising edge with reset = 1.
- Reset asserted mid-operation: any pending result is discarded and out_valid drops immediately.
- X or unknown input bits propagate only to their own mapped output bit positions.

Optional Feature:
- Macro PLAYER_INVERSE_EN.
- When defined:
  - Adds input port `inverse` (1 bit).
  - When inverse = 1, apply the inverse mapping permuted[(4*j) mod M] = original[j] for j < M, with permuted[M] = original[M]. This is the decryption P-layer.
  - When inverse = 0, behaviour is identical to the forward mapping.
  - `inverse` is sampled combinationally, and the register stage captures whichever mapping is selected.
- When not defined: the port is absent and the forward mapping only is built.

Test Plan:
- original = 0x0000000000000001 -> permuted = 0x0000000000000001; original = 0x0000000000000002 -> permuted = 0x0000000000010000.
- original = 0x0000000000000010 -> permuted = 0x0000000000000002; original = 0x8000000000000000 -> permuted = 0x8000000000000000.
- original = 0x000000000000FFFF -> permuted = 0x000F000F000F000F; original = 0xFFFFFFFFFFFFFFFF -> all-ones; 0 -> 0.
- Walking-one over all 64 positions; check the single set output bit at 16i mod 63 (63 -> 63). Random vectors compared against a reference model.
- Register stage:
  - Hold reset = 0, then release; assert in_valid with 0x000000000000000F.
  - Next edge: permuted_q = 0x0001000100010001 and out_valid = 1.
  - Drop in_valid: out_valid = 0 and permuted_q holds.
  - Assert reset mid-stream: both outputs clear immediately, without waiting for a clock edge.
- With PLAYER_INVERSE_EN: inverse = 1 on 0x0000000000010000 -> 0x0000000000000002. Forward then inverse on 1000 random vectors returns the original.
